ps2_mouse_tracker: RTL and testbench
====================================

// Module: ps2_mouse_tracker
// PURPOSE
//  Parametrised packet engine between ps2_receiver and the application.
//  - Assembles standard 3-byte or IntelliMouse 4-byte (wheel) PS/2 mouse packets from the receiver byte stream.
//  - Resynchronises on framing, parity and timeout faults.
//  - Keeps a clamped screen-space cursor position, wheel deltas and button press/release events.
//  - Runs after ps2_mouse_init reaches stream mode. Replaces the fixed 3-byte decode inside it.
// PARAMETERS
//  CLK_HZ      27_000_000  system clock frequency
//  TIMEOUT_US  2000        max gap between bytes of one packet
//  POS_W       11          width of pos_x / pos_y
//  X_MAX       639         pos_x upper clamp (lower clamp is 0)
//  Y_MAX       479         pos_y upper clamp (lower clamp is 0)
//  INVERT_Y    1           1: pos_y -= dy (screen down = +); 0: pos_y += dy
// PORTS
//  clk          in   1      system clock
//  rst          in   1      reset; asynchronous, active-high
//  rx_data      in   8      byte from ps2_receiver
//  rx_ready     in   1      1-cycle strobe: rx_data valid
//  rx_error     in   1      1-cycle strobe: parity/frame error
//  wheel_mode   in   1      1: 4-byte packets, 0: 3-byte packets
//  recenter     in   1      pulse: move cursor to (X_MAX>>1, Y_MAX>>1)
//  pos_x        out  POS_W  clamped cursor X
//  pos_y        out  POS_W  clamped cursor Y
//  dx, dy       out  9      signed deltas of last packet
//  dz           out  4      signed wheel delta of last packet (0 in 3-byte mode)
//  buttons      out  3      {M,R,L} level of last packet
//  btn_press    out  3      1-cycle pulse per button, 0->1
//  btn_release  out  3      1-cycle pulse per button, 1->0
//  pkt_valid    out  1      1-cycle pulse: outputs updated
//  sync_err     out  1      1-cycle pulse: byte0 rejected (bit3=0)
//  timeout_err  out  1      1-cycle pulse: partial packet dropped on timeout
// BEHAVIOUR
//  - Reset values:
//    - pos_x = X_MAX>>1, pos_y = Y_MAX>>1.
//    - All other outputs 0. FSM in S_B0. Timeout counter 0.
//  - FSM states: S_B0 -> S_B1 -> S_B2 -> (S_B3 if packet is 4-byte) -> S_B0. Advances only on rx_ready.
//  - S_B0:
//    - Byte with bit3=1 is latched as status; go to S_B1.
//    - Byte with bit3=0 is discarded; sync_err pulses; stay in S_B0.
//  - wheel_mode is sampled only when status is accepted in S_B0. It is held for the rest of that packet.
//  - Any rx_error drops the partial packet and returns to S_B0. No error pulse from this block.
//    rx_error wins if it coincides with rx_ready.
//  - Timeout counter:
//    - Clears on every rx_ready and whenever the FSM is in S_B0.
//    - Counts in S_B1..S_B3.
//    - At TIMEOUT_CYCLES = CLK_HZ/1_000_000*TIMEOUT_US: go to S_B0, timeout_err pulses once.
//  - Deltas: dx = {st[4],b1}, dy = {st[5],b2}.
//    - If st[6] (X overflow) is set: dx saturates to +255 (sign 0) or -256 (sign 1).
//    - st[7] overflow on Y is handled the same way.
//  - dz = b3[3:0]; b3[7:4] is ignored.
//  - Update cycle: the cycle after the final byte's rx_ready. All outputs register together with pkt_valid high.
//    Latency is 1 clk.
//  - Position update:
//    - Compute in POS_W+2 signed bits: pos_x + dx, and pos_y -/+ dy.
//    - Result < 0 is clamped to 0; result > MAX is clamped to MAX.
//  - btn_press = new & ~old; btn_release = ~new & old. Both only on pkt_valid.
//  - recenter sets the position to centre on the next clk. If it coincides with a packet update:
//    - recenter wins for pos.
//    - dx/dy/dz/buttons/pkt_valid still update.
//  - Async rst mid-packet: partial packet lost, outputs back to reset values immediately.
// STRUCTURE
//  - ps2_mouse_pkg holds:
//    - FSM state localparams S_B0..S_B3.
//    - Status bit indices BIT_L, BIT_R, BIT_M, BIT_SYNC=3, BIT_XS, BIT_YS, BIT_XO, BIT_YO.
//    - Constants DELTA_MAX=255, DELTA_MIN=-256.
//  - Sub-module ps2_sat_accum (POS_W, MAX): signed add with 0..MAX clamp. Instantiated for X and Y.
// TESTING
//  All cases use X_MAX=639, Y_MAX=479, INVERT_Y=1. Start state after rst is pos (319,239).
//  1. 3-byte 08,05,05 -> pkt_valid 1 cycle after byte 3; dx=5, dy=5, pos=(324,234), buttons=000.
//  2. 39,F9,F9 -> dx=-7, dy=-7, buttons=001, btn_press=001.
//     Next packet 08,00,00 -> btn_release=001.
//  3. Ten packets 18,80,00 (dx=-128 each) -> pos_x clamps at 0, never wraps.
//     Then 48,00,00 (X overflow, positive sign) -> dx=+255.
//  4. Byte 00, then 08,01,01 -> sync_err once, no pkt_valid for 00; valid packet dx=1.
//  5. 08,05, then idle > TIMEOUT -> timeout_err once.
//     Next 08,02,02 -> dx=2 (no mix with the stale byte).
//  6. wheel_mode=1: 08,00,00,0F -> dz=-1 only after byte 4.
//     Same bytes with rx_error on byte 3 -> no pkt_valid; recovers on next packet.

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg: shared packet FSM states, status bit indices and delta saturation for the PS/2 mouse tracker
package ps2_mouse_pkg;
    typedef enum logic [1:0] {S_B0, S_B1, S_B2, S_B3} state_t;
    localparam int BIT_L = 0;
    localparam int BIT_R = 1;
    localparam int BIT_M = 2;
    localparam int BIT_SYNC = 3;
    localparam int BIT_XS = 4;
    localparam int BIT_YS = 5;
    localparam int BIT_XO = 6;
    localparam int BIT_YO = 7;
    localparam logic signed [8:0] DELTA_MAX = 9'sh0FF;
    localparam logic signed [8:0] DELTA_MIN = 9'sh100;
    function automatic logic signed [8:0] sat_delta(input logic sign, input logic ovf, input logic [7:0] b);
        return ovf ? (sign ? DELTA_MIN : DELTA_MAX) : $signed({sign, b});
    endfunction
endpackage

// File: rtl/ps2_sat_accum.sv
// ps2_sat_accum: adds or subtracts a 9-bit signed delta to a position and clamps the result to 0..MAX
module ps2_sat_accum #(
    parameter int POS_W = 11,
    parameter int MAX = 639
) (
    input  logic [POS_W-1:0]  pos,
    input  logic signed [8:0] delta,
    input  logic              sub,
    output logic [POS_W-1:0]  sum
);
    logic signed [POS_W+1:0] p, d, s;
    always_comb begin
        p = $signed({2'b00, pos});
        d = $signed({{(POS_W-7){delta[8]}}, delta});
        s = sub ? p - d : p + d;
        sum = s[POS_W+1] ? '0 : (s > $signed((POS_W+2)'(MAX))) ? POS_W'(MAX) : s[POS_W-1:0];
    end
endmodule

// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker: assembles 3/4-byte PS/2 mouse packets into clamped cursor position, deltas and button events
module ps2_mouse_tracker
    import ps2_mouse_pkg::*;
#(
    parameter int CLK_HZ = 27_000_000,
    parameter int TIMEOUT_US = 2000,
    parameter int POS_W = 11,
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479,
    parameter int INVERT_Y = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_error,
    input  logic              wheel_mode,
    input  logic              recenter,
    output logic [POS_W-1:0]  pos_x,
    output logic [POS_W-1:0]  pos_y,
    output logic signed [8:0] dx,
    output logic signed [8:0] dy,
    output logic signed [3:0] dz,
    output logic [2:0]        buttons,
    output logic [2:0]        btn_press,
    output logic [2:0]        btn_release,
    output logic              pkt_valid,
    output logic              sync_err,
    output logic              timeout_err
);
    localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [POS_W-1:0] CX = POS_W'(X_MAX >> 1);
    localparam logic [POS_W-1:0] CY = POS_W'(Y_MAX >> 1);

    state_t state, state_n;
    logic [7:4] sflag;
    logic [2:0] sbtn;
    logic [7:0] b1, b2, yb;
    logic wm, take, fin, to_hit;
    logic [CW-1:0] cnt;
    logic signed [8:0] dx_n, dy_n;
    logic signed [3:0] dz_n;
    logic [POS_W-1:0] px_n, py_n;

    always_comb begin
        take = rx_ready & ~rx_error;
        to_hit = (state != S_B0) && (cnt == CW'(TIMEOUT_CYCLES)) && !rx_ready && !rx_error;
        fin = take && (state == S_B3 || (state == S_B2 && !wm));
        state_n = rx_error ? S_B0 :
                  rx_ready ? ((state == S_B0) ? (rx_data[BIT_SYNC] ? S_B1 : S_B0) :
                              (state == S_B1) ? S_B2 :
                              (state == S_B2 && wm) ? S_B3 : S_B0) :
                  to_hit ? S_B0 : state;
        // in 3-byte packets the Y byte is the one arriving right now
        yb = (state == S_B2) ? rx_data : b2;
        dx_n = sat_delta(sflag[BIT_XS], sflag[BIT_XO], b1);
        dy_n = sat_delta(sflag[BIT_YS], sflag[BIT_YO], yb);
        dz_n = (state == S_B3) ? $signed(rx_data[3:0]) : 4'sd0;
    end

    ps2_sat_accum #(.POS_W(POS_W), .MAX(X_MAX)) u_acc_x (
        .pos(pos_x), .delta(dx_n), .sub(1'b0), .sum(px_n)
    );
    ps2_sat_accum #(.POS_W(POS_W), .MAX(Y_MAX)) u_acc_y (
        .pos(pos_y), .delta(dy_n), .sub(INVERT_Y != 0), .sum(py_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_B0;
            cnt <= '0;
            sflag <= '0;
            sbtn <= '0;
            b1 <= '0;
            b2 <= '0;
            wm <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= (state_n == S_B0 || rx_ready) ? '0 : cnt + 1'b1;
            if (take && state == S_B0 && rx_data[BIT_SYNC]) begin
                sflag <= rx_data[7:4];
                sbtn <= rx_data[2:0];
                wm <= wheel_mode;
            end
            if (take && state == S_B1) b1 <= rx_data;
            if (take && state == S_B2) b2 <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x <= CX;
            pos_y <= CY;
            dx <= '0;
            dy <= '0;
            dz <= '0;
            buttons <= '0;
            btn_press <= '0;
            btn_release <= '0;
            pkt_valid <= 1'b0;
            sync_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            pkt_valid <= fin;
            sync_err <= take && state == S_B0 && !rx_data[BIT_SYNC];
            timeout_err <= to_hit;
            btn_press <= fin ? sbtn & ~buttons : 3'b000;
            btn_release <= fin ? ~sbtn & buttons : 3'b000;
            pos_x <= recenter ? CX : fin ? px_n : pos_x;
            pos_y <= recenter ? CY : fin ? py_n : pos_y;
            if (fin) begin
                dx <= dx_n;
                dy <= dy_n;
                dz <= dz_n;
                buttons <= sbtn;
            end
        end
    end
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// tb_ps2_mouse_tracker: directed packet sequences with hand-computed expectations for ps2_mouse_tracker
module tb_ps2_mouse_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic rx_ready = 1'b0;
    logic rx_error = 1'b0;
    logic wheel_mode = 1'b0;
    logic recenter = 1'b0;
    logic [10:0] pos_x, pos_y;
    logic signed [8:0] dx, dy;
    logic signed [3:0] dz;
    logic [2:0] buttons, btn_press, btn_release;
    logic pkt_valid, sync_err, timeout_err;
    int errors = 0;
    int checks = 0;

    ps2_mouse_tracker #(
        .CLK_HZ(27_000_000), .TIMEOUT_US(20), .POS_W(11),
        .X_MAX(639), .Y_MAX(479), .INVERT_Y(1)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error),
        .wheel_mode(wheel_mode), .recenter(recenter), .pos_x(pos_x), .pos_y(pos_y),
        .dx(dx), .dy(dy), .dz(dz), .buttons(buttons), .btn_press(btn_press),
        .btn_release(btn_release), .pkt_valid(pkt_valid), .sync_err(sync_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic err = 1'b0);
        rx_data = b;
        rx_ready = 1'b1;
        rx_error = err;
        tick();
        rx_ready = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic pkt3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send(a); tick();
        send(b); tick();
        send(c);
    endtask

    initial begin
        int n;
        tick(); tick();
        check("rst_pos_x", 32'(pos_x), 319);
        check("rst_pos_y", 32'(pos_y), 239);
        check("rst_dx", $signed(dx), 0);
        check("rst_valid", 32'(pkt_valid), 0);
        check("rst_btn", 32'(buttons), 0);
        rst = 1'b0;
        tick();

        pkt3(8'h08, 8'h05, 8'h05);
        check("t1_valid", 32'(pkt_valid), 1);
        check("t1_dx", $signed(dx), 5);
        check("t1_dy", $signed(dy), 5);
        check("t1_pos_x", 32'(pos_x), 324);
        check("t1_pos_y", 32'(pos_y), 234);
        check("t1_btn", 32'(buttons), 0);
        check("t1_dz", $signed(dz), 0);
        tick();
        check("t1_valid_drop", 32'(pkt_valid), 0);

        pkt3(8'h39, 8'hF9, 8'hF9);
        check("t2_dx", $signed(dx), -7);
        check("t2_dy", $signed(dy), -7);
        check("t2_pos_x", 32'(pos_x), 317);
        check("t2_pos_y", 32'(pos_y), 241);
        check("t2_btn", 32'(buttons), 1);
        check("t2_press", 32'(btn_press), 1);
        tick();
        check("t2_press_pulse", 32'(btn_press), 0);
        pkt3(8'h08, 8'h00, 8'h00);
        check("t2_release", 32'(btn_release), 1);
        check("t2_press_none", 32'(btn_press), 0);
        tick();

        for (int i = 0; i < 10; i++) begin
            pkt3(8'h18, 8'h80, 8'h00);
            if (i == 1) check("t3_pos_x_mid", 32'(pos_x), 61);
            tick();
        end
        check("t3_dx", $signed(dx), -128);
        check("t3_pos_x_clamp", 32'(pos_x), 0);
        pkt3(8'h48, 8'h00, 8'h00);
        check("t3_xovf_dx", $signed(dx), 255);
        check("t3_xovf_pos", 32'(pos_x), 255);
        tick();

        send(8'h00);
        check("t4_sync_err", 32'(sync_err), 1);
        check("t4_no_valid", 32'(pkt_valid), 0);
        tick();
        check("t4_sync_pulse", 32'(sync_err), 0);
        pkt3(8'h08, 8'h01, 8'h01);
        check("t4_dx", $signed(dx), 1);
        check("t4_pos", 32'({pos_x, pos_y}), 32'({11'd256, 11'd240}));
        tick();

        send(8'h08); tick();
        send(8'h05);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (timeout_err) n++;
            tick();
        end
        check("t5_timeout_once", n, 1);
        pkt3(8'h08, 8'h02, 8'h02);
        check("t5_dx", $signed(dx), 2);
        check("t5_dy", $signed(dy), 2);
        check("t5_pos", 32'({pos_x, pos_y}), 32'({11'd258, 11'd238}));
        tick();

        wheel_mode = 1'b1;
        pkt3(8'h08, 8'h00, 8'h00);
        check("t6_no_valid_b3", 32'(pkt_valid), 0);
        tick();
        send(8'h0F);
        check("t6_valid_b4", 32'(pkt_valid), 1);
        check("t6_dz", $signed(dz), -1);
        tick();
        send(8'h08); tick();
        send(8'h00); tick();
        send(8'h00, 1'b1);
        tick();
        check("t6_err_no_valid", 32'(pkt_valid), 0);
        send(8'h08); tick();
        send(8'h03); tick();
        send(8'h00); tick();
        send(8'h0E);
        check("t6_recover_dx", $signed(dx), 3);
        check("t6_recover_dz", $signed(dz), -2);
        check("t6_recover_pos_x", 32'(pos_x), 261);
        tick();

        wheel_mode = 1'b0;
        send(8'h08); tick();
        wheel_mode = 1'b1;
        send(8'h01); tick();
        send(8'h01);
        check("t7_latched_3byte", 32'(pkt_valid), 1);
        check("t7_dz", $signed(dz), 0);
        check("t7_pos", 32'({pos_x, pos_y}), 32'({11'd262, 11'd237}));
        wheel_mode = 1'b0;
        tick();

        send(8'h08); tick();
        send(8'h0A); tick();
        recenter = 1'b1;
        send(8'h0A);
        recenter = 1'b0;
        check("t8_recenter_valid", 32'(pkt_valid), 1);
        check("t8_recenter_dx", $signed(dx), 10);
        check("t8_recenter_pos", 32'({pos_x, pos_y}), 32'({11'd319, 11'd239}));
        tick();

        pkt3(8'h28, 8'h00, 8'h80);
        check("t9_dy", $signed(dy), -128);
        check("t9_pos_y", 32'(pos_y), 367);
        tick();
        pkt3(8'h28, 8'h00, 8'h80);
        check("t9_pos_y_clamp", 32'(pos_y), 479);
        tick();

        send(8'h08); tick();
        send(8'h05);
        #3 rst = 1'b1;
        #1;
        check("t10_async_pos_y", 32'(pos_y), 239);
        check("t10_async_dy", $signed(dy), 0);
        tick();
        rst = 1'b0;
        tick();
        pkt3(8'h08, 8'h04, 8'h04);
        check("t10_after_rst_dx", $signed(dx), 4);
        check("t10_after_rst_pos", 32'({pos_x, pos_y}), 32'({11'd323, 11'd235}));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
